// File: rtl/write_back_unit_if.sv
// Bundle between the execute/memory side and the write-back stage: producer
// inputs, register-file write port, hazard mask, stall and error flag.
interface write_back_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GPR_WIDTH  = 3
) ();
  localparam int unsigned NUM_REGS = 1 << GPR_WIDTH;

  logic                  exec_valid;
  logic [GPR_WIDTH-1:0]  exec_dest;
  logic [DATA_WIDTH-1:0] exec_data;
  logic                  load_issue;
  logic [GPR_WIDTH-1:0]  load_dest;
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  write_enable;
  logic [GPR_WIDTH-1:0]  write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [NUM_REGS-1:0]   pending_mask;
  logic                  stall;
  logic                  protocol_error;

  modport master (
    output exec_valid, exec_dest, exec_data,
    output load_issue, load_dest, mem_valid, mem_data,
    input  write_enable, write_address, write_data,
    input  pending_mask, stall, protocol_error
  );

  modport slave (
    input  exec_valid, exec_dest, exec_data,
    input  load_issue, load_dest, mem_valid, mem_data,
    output write_enable, write_address, write_data,
    output pending_mask, stall, protocol_error
  );
endinterface

// File: rtl/write_back_unit.sv
// Register-file write side: arbitrates load responses, skidded and fresh ALU
// results onto one write port, tracks outstanding load destinations.
module write_back_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GPR_WIDTH  = 3,
  parameter int unsigned LOAD_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  write_back_unit_if.slave  bus
);
  localparam int unsigned NUM_REGS = 1 << GPR_WIDTH;
  localparam int unsigned PTR_W    = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(LOAD_DEPTH + 1);

  logic [GPR_WIDTH-1:0]  fifo_q [LOAD_DEPTH];
  logic [GPR_WIDTH-1:0]  fifo_d [LOAD_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [GPR_WIDTH-1:0]  skid_dest_q, skid_dest_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  wr_en_q, wr_en_d;
  logic [GPR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  err_q, err_d;

  logic                  stall_c;
  logic                  fifo_full_c, fifo_empty_c;
  logic                  exec_ok_c, load_ok_c, mem_ok_c, illegal_c;
  logic [NUM_REGS-1:0]   pending_c;
  logic [PTR_W-1:0]      offset_c;

  // Qualify requests against registered state only
  always_comb begin
    fifo_full_c  = (count_q == CNT_W'(LOAD_DEPTH));
    fifo_empty_c = (count_q == '0);
    stall_c      = skid_valid_q | fifo_full_c;
    exec_ok_c    = bus.exec_valid & ~stall_c;
    load_ok_c    = bus.load_issue & ~stall_c;
    mem_ok_c     = bus.mem_valid & ~fifo_empty_c;
    illegal_c    = (bus.exec_valid & stall_c) | (bus.load_issue & stall_c) |
                   (bus.mem_valid & fifo_empty_c);
  end

  // Pending mask: entries between read pointer and read pointer + count
  always_comb begin
    pending_c = '0;
    offset_c  = '0;
    for (int unsigned i = 0; i < LOAD_DEPTH; i++) begin
      offset_c = PTR_W'(PTR_W'(i) - rd_ptr_q);
      if (CNT_W'(offset_c) < count_q) pending_c[fifo_q[i]] = 1'b1;
    end
  end

  // Write-port arbitration, skid capture and FIFO update
  always_comb begin
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    skid_valid_d = skid_valid_q;
    skid_dest_d  = skid_dest_q;
    skid_data_d  = skid_data_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    err_d        = err_q | illegal_c;

    if (mem_ok_c) begin
      wr_en_d   = 1'b1;
      wr_addr_d = fifo_q[rd_ptr_q];
      wr_data_d = bus.mem_data;
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      if (exec_ok_c) begin
        skid_valid_d = 1'b1;
        skid_dest_d  = bus.exec_dest;
        skid_data_d  = bus.exec_data;
      end
    end else if (skid_valid_q) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = skid_dest_q;
      wr_data_d    = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (exec_ok_c) begin
      wr_en_d   = 1'b1;
      wr_addr_d = bus.exec_dest;
      wr_data_d = bus.exec_data;
    end

    if (load_ok_c) begin
      fifo_d[wr_ptr_q] = bus.load_dest;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    case ({load_ok_c, mem_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LOAD_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_dest_q  <= '0;
      skid_data_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      skid_valid_q <= skid_valid_d;
      skid_dest_q  <= skid_dest_d;
      skid_data_q  <= skid_data_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      err_q        <= err_d;
    end
  end

  assign bus.write_enable   = wr_en_q;
  assign bus.write_address  = wr_addr_q;
  assign bus.write_data     = wr_data_q;
  assign bus.pending_mask   = pending_c;
  assign bus.stall          = stall_c;
  assign bus.protocol_error = err_q;
endmodule

// File: tb/tb_write_back_unit.sv
// Directed bench for write_back_unit: exec writes, loads, skid, hazards, errors.
module tb_write_back_unit;
  localparam int unsigned DW = 32;
  localparam int unsigned GW = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  write_back_unit_if #(.DATA_WIDTH(DW), .GPR_WIDTH(GW)) bus ();

  write_back_unit #(.DATA_WIDTH(DW), .GPR_WIDTH(GW), .LOAD_DEPTH(2)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic idle();
    bus.exec_valid = 1'b0; bus.exec_dest = '0; bus.exec_data = '0;
    bus.load_issue = 1'b0; bus.load_dest = '0;
    bus.mem_valid  = 1'b0; bus.mem_data  = '0;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic exec(input logic [2:0] d, input logic [31:0] v);
    bus.exec_valid = 1'b1; bus.exec_dest = d; bus.exec_data = v;
  endtask

  task automatic load(input logic [2:0] d);
    bus.load_issue = 1'b1; bus.load_dest = d;
  endtask

  task automatic resp(input logic [31:0] v);
    bus.mem_valid = 1'b1; bus.mem_data = v;
  endtask

  task automatic expect_write(input string tag, input logic [2:0] a, input logic [31:0] v);
    check({tag, "_we"},   32'(bus.write_enable), 32'd1);
    check({tag, "_addr"}, 32'(bus.write_address), 32'(a));
    check({tag, "_data"}, bus.write_data, v);
  endtask

  initial begin
    idle();
    cycle(); cycle();
    check("rst_we",    32'(bus.write_enable), 32'd0);
    check("rst_addr",  32'(bus.write_address), 32'd0);
    check("rst_data",  bus.write_data, 32'd0);
    check("rst_pend",  32'(bus.pending_mask), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_err",   32'(bus.protocol_error), 32'd0);
    reset = 1'b1;
    cycle();

    // Plain ALU write, one cycle latency, single-cycle strobe, hold after
    exec(3'd3, 32'h1234); cycle(); idle();
    expect_write("exec1", 3'd3, 32'h1234);
    check("exec1_stall", 32'(bus.stall), 32'd0);
    cycle();
    check("exec1_we_off", 32'(bus.write_enable), 32'd0);
    check("exec1_hold_addr", 32'(bus.write_address), 32'd3);
    check("exec1_hold_data", bus.write_data, 32'h1234);

    // Single load and its response
    load(3'd5); cycle(); idle();
    check("ld5_pend", 32'(bus.pending_mask), 32'h20);
    check("ld5_we", 32'(bus.write_enable), 32'd0);
    cycle(); cycle();
    resp(32'hCAFE); cycle(); idle();
    expect_write("ld5_wr", 3'd5, 32'hCAFE);
    check("ld5_pend_clr", 32'(bus.pending_mask), 32'd0);

    // Fill the FIFO, drain in order
    load(3'd1); cycle(); load(3'd2); cycle(); idle();
    check("full_stall", 32'(bus.stall), 32'd1);
    check("full_pend", 32'(bus.pending_mask), 32'h06);
    resp(32'hA); cycle(); idle();
    expect_write("drain1", 3'd1, 32'hA);
    check("drain1_stall", 32'(bus.stall), 32'd0);
    check("drain1_pend", 32'(bus.pending_mask), 32'h04);
    resp(32'hB); cycle(); idle();
    expect_write("drain2", 3'd2, 32'hB);
    check("drain2_pend", 32'(bus.pending_mask), 32'd0);

    // Response and ALU result collide: ALU result skids one cycle
    load(3'd4); cycle(); idle();
    check("skid_pend", 32'(bus.pending_mask), 32'h10);
    resp(32'h77); exec(3'd6, 32'h99); cycle(); idle();
    expect_write("skid_mem", 3'd4, 32'h77);
    check("skid_stall1", 32'(bus.stall), 32'd1);
    cycle();
    expect_write("skid_exec", 3'd6, 32'h99);
    check("skid_stall0", 32'(bus.stall), 32'd0);
    cycle();
    check("skid_idle_we", 32'(bus.write_enable), 32'd0);

    // Same-cycle pop and push to the same register
    load(3'd2); cycle(); idle();
    resp(32'h5); load(3'd2); cycle(); idle();
    expect_write("pp_wr", 3'd2, 32'h5);
    check("pp_pend", 32'(bus.pending_mask), 32'h04);
    check("pp_stall", 32'(bus.stall), 32'd0);
    resp(32'h6); cycle(); idle();
    expect_write("pp_wr2", 3'd2, 32'h6);
    check("pp_pend_clr", 32'(bus.pending_mask), 32'd0);
    check("pp_err0", 32'(bus.protocol_error), 32'd0);

    // Illegal traffic while stalled
    load(3'd1); cycle(); load(3'd7); cycle(); idle();
    check("ill_stall", 32'(bus.stall), 32'd1);
    check("ill_err_pre", 32'(bus.protocol_error), 32'd0);
    exec(3'd3, 32'h55); cycle(); idle();
    check("ill_exec_we", 32'(bus.write_enable), 32'd0);
    check("ill_exec_err", 32'(bus.protocol_error), 32'd1);
    load(3'd4); cycle(); idle();
    check("ill_load_pend", 32'(bus.pending_mask), 32'h82);
    resp(32'h1); cycle(); idle();
    expect_write("ill_drain1", 3'd1, 32'h1);
    resp(32'h2); cycle(); idle();
    expect_write("ill_drain2", 3'd7, 32'h2);
    check("ill_drain_pend", 32'(bus.pending_mask), 32'd0);
    check("ill_err_sticky", 32'(bus.protocol_error), 32'd1);

    // Reset mid-operation drops the load; late response is an error
    load(3'd5); cycle(); idle();
    check("mid_pend", 32'(bus.pending_mask), 32'h20);
    reset = 1'b0; #2;
    check("mid_rst_pend", 32'(bus.pending_mask), 32'd0);
    check("mid_rst_err", 32'(bus.protocol_error), 32'd0);
    check("mid_rst_we", 32'(bus.write_enable), 32'd0);
    reset = 1'b1;
    cycle();
    resp(32'hDD); cycle(); idle();
    check("late_we", 32'(bus.write_enable), 32'd0);
    check("late_err", 32'(bus.protocol_error), 32'd1);
    cycle();
    check("late_err_sticky", 32'(bus.protocol_error), 32'd1);
    check("late_stall", 32'(bus.stall), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/write_back_unit.md
# write_back_unit

Final pipeline stage: the write side of the register file read by the decode stage. Collects ALU results from execute and in-order load responses from data memory and drives the single register-file write port. Arbitration, a one-entry skid buffer, a load-destination FIFO, a pending-load scoreboard for hazard detection, and a stall back to upstream.

## Interface
- DATA_WIDTH, 32, register data width
- GPR_WIDTH, 3, register address width (2^GPR_WIDTH registers)
- LOAD_DEPTH, 2, max outstanding loads (power of two, ≥2)

- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- exec_valid  in  1  ALU result present this cycle
- exec_dest  in  GPR_WIDTH  ALU destination register
- exec_data  in  DATA_WIDTH  ALU result
- load_issue  in  1  load sent to memory this cycle
- load_dest  in  GPR_WIDTH  destination of issued load
- mem_valid  in  1  load response present (responses return in issue order)
- mem_data  in  DATA_WIDTH  load response data
- write_enable  out  1  register-file write strobe, registered
- write_address  out  GPR_WIDTH  write register, registered
- write_data  out  DATA_WIDTH  write data, registered
- pending_mask  out  2^GPR_WIDTH  bit r set while a load to r is outstanding
- stall  out  1  upstream must hold; no exec_valid/load_issue accepted
- protocol_error  out  1  sticky error flag

## Operation
- Load FIFO: LOAD_DEPTH entries of destinations. load_issue pushes load_dest; mem_valid pops head. Read/write pointers wrap modulo LOAD_DEPTH; count range 0..LOAD_DEPTH.
- Skid buffer: one entry {dest, data} plus skid_valid.
- Write-port priority each cycle: (1) mem_valid with non-empty FIFO: write head dest with mem_data; (2) else skid_valid: write skid entry, clear skid_valid; (3) else exec_valid accepted: write exec_dest/exec_data; (4) else write_enable=0.
- exec_valid accepted while the port is taken by a memory response: exec result goes to the skid buffer.
- stall = skid_valid OR (FIFO count == LOAD_DEPTH); combinational from registered state only.
- Illegal events, each ignored (no state change) and setting protocol_error: exec_valid while stall; load_issue while stall; mem_valid with FIFO empty.
- Same-cycle load_issue and mem_valid: pop and push both occur; count unchanged.
- pending_mask[r] = OR over valid FIFO entries of (dest==r); combinational from FIFO state. A popped entry clears in the cycle after the response; a pushed entry sets in the cycle after issue.
- WAW/RAW against pending loads are resolved upstream using pending_mask; this block does not reorder.
- protocol_error clears only on reset.

## Timing
- Reset (async, active-low): write_enable=0, write_address=0, write_data=0, FIFO empty, skid_valid=0, pending_mask=0, stall=0, protocol_error=0. Reset mid-operation discards outstanding loads and skid contents. Late responses then raise protocol_error.
- Latency: input accepted in cycle N appears on write_* in N+1 for exactly one cycle. A skidded exec result writes in the first cycle with no memory response, at the earliest N+2.
- Skid wait is bounded by LOAD_DEPTH cycles because no loads are issued while stall is high.
- Write port never writes twice in one cycle. write_address/write_data hold their last value when write_enable=0.

## Test plan
- Reset then exec_valid dest=3 data=0x1234 at cycle 1 -> write_enable=1, address 3, data 0x1234 at cycle 2 only; stall stays 0.
- load_issue dest=5 -> pending_mask=0x20 next cycle. mem_valid data=0xCAFE 3 cycles later -> write r5=0xCAFE one cycle after; pending_mask=0 same cycle as the write.
- Issue loads r1, r2 -> stall=1 (FIFO full). Responses 0xA, 0xB -> writes r1=0xA then r2=0xB in order; stall drops after first pop.
- mem_valid (r4, 0x77) and exec_valid (r6, 0x99) same cycle N -> N+1 write r4=0x77 with stall=1; N+2 write r6=0x99; stall 0 at N+2.
- mem_valid with empty FIFO -> no write, protocol_error=1 and stays 1. exec_valid while stall -> ignored, no write.
- Load r2 outstanding, then same-cycle mem_valid 0x5 and load_issue r2 -> write r2=0x5; pending_mask bit 2 stays set; FIFO count 1.
